// File: rtl/uart_out_arbiter.sv
// uart_out_arbiter: packet-granular round-robin arbiter with credit back-pressure in front of the UART output buffer
module uart_out_arbiter #(
  parameter int N_REQ = 2,
  parameter int DEPTH = 40000,
  parameter int CNT_W = 17
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               tx_done,
  output logic [CNT_W-1:0]   occupancy,
  output logic               full,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               underflow
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [2:0] grant_id_q, grant_id_d, last_grant_q, last_grant_d, pick;
  logic [7:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, underflow_q, underflow_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [N_REQ-1:0] hs_vec;
  logic hs, hs_last;
  assign full = occ_q == CNT_W'(DEPTH);
  assign busy = state_q == GRANT;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign occupancy = occ_q;
  assign grant_id = grant_id_q;
  assign underflow = underflow_q;
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) req_ready[i] = busy && !full && grant_id_q == 3'(i);
  end
  always_comb begin
    pick = grant_id_q;
    for (int k = N_REQ; k >= 1; k--)
      if (req_valid[(int'(last_grant_q) + k) % N_REQ]) pick = 3'((int'(last_grant_q) + k) % N_REQ);
  end
  always_comb begin
    hs_vec = req_valid & req_ready;
    hs = |hs_vec;
    hs_last = |(hs_vec & req_last);
    out_data_d = out_data_q;
    for (int i = 0; i < N_REQ; i++) if (hs_vec[i]) out_data_d = req_data[8*i +: 8];
    out_valid_d = hs;
    state_d = state_q;
    grant_id_d = grant_id_q;
    last_grant_d = last_grant_q;
    if (state_q == IDLE && |req_valid) begin
      state_d = GRANT;
      grant_id_d = pick;
    end
    if (hs_last) begin
      state_d = IDLE;
      last_grant_d = grant_id_q;
    end
    occ_d = hs && !tx_done ? occ_q + 1'b1 : !hs && tx_done && occ_q != '0 ? occ_q - 1'b1 : occ_q;
    underflow_d = underflow_q | (tx_done && !hs && occ_q == '0);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_id_q <= '0;
      last_grant_q <= 3'(N_REQ - 1);
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      occ_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_id_q <= grant_id_d;
      last_grant_q <= last_grant_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      occ_q <= occ_d;
      underflow_q <= underflow_d;
    end
  end
endmodule

// File: tb/tb_uart_out_arbiter.sv
// tb_uart_out_arbiter: directed self-checking bench for uart_out_arbiter
module tb_uart_out_arbiter;
  logic clk = 1'b0, rstn = 1'b0, tx_done = 1'b0;
  logic [1:0] req_valid = '0, req_last = '0;
  logic [15:0] req_data = '0;
  logic [1:0] req_ready, s_req_ready;
  logic [7:0] out_data, s_out_data;
  logic out_valid, full, busy, underflow, s_out_valid, s_full, s_busy, s_underflow;
  logic [16:0] occupancy;
  logic [2:0] s_occ, grant_id, s_grant_id;
  int checks = 0, errors = 0;

  uart_out_arbiter dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid), .tx_done(tx_done),
    .occupancy(occupancy), .full(full), .grant_id(grant_id), .busy(busy), .underflow(underflow)
  );

  uart_out_arbiter #(.N_REQ(2), .DEPTH(4), .CNT_W(3)) dut_s (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(s_req_ready), .out_data(s_out_data), .out_valid(s_out_valid), .tx_done(tx_done),
    .occupancy(s_occ), .full(s_full), .grant_id(s_grant_id), .busy(s_busy), .underflow(s_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    tx_done = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (occupancy !== 17'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if ({full, busy, underflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {full, busy, underflow}); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    checks++; if ({s_occ, s_full} !== 4'b0000) begin errors++; $display("FAIL reset_small: got %b want 0000", {s_occ, s_full}); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 2'b01;
    req_data = 16'h0041;
    step();
    checks++; if (busy !== 1'b1 || grant_id !== 3'd0) begin errors++; $display("FAIL single_grant: got busy=%b id=%0d want busy=1 id=0", busy, grant_id); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_bubble: got %b want 0", out_valid); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
    step();
    req_data = 16'h0042;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin errors++; $display("FAIL single_b0: got v=%b d=%h want v=1 d=41", out_valid, out_data); end
    step();
    req_data = 16'h0043;
    req_last = 2'b01;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h42) begin errors++; $display("FAIL single_b1: got v=%b d=%h want v=1 d=42", out_valid, out_data); end
    step();
    req_valid = 2'b00;
    req_last = 2'b00;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h43) begin errors++; $display("FAIL single_b2: got v=%b d=%h want v=1 d=43", out_valid, out_data); end
    checks++; if (busy !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL single_idle: got busy=%b ready=%b want 0 00", busy, req_ready); end
    checks++; if (occupancy !== 17'd3) begin errors++; $display("FAIL single_occ: got %0d want 3", occupancy); end
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 17'd3) begin errors++; $display("FAIL single_after: got v=%b occ=%0d want 0 3", out_valid, occupancy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] cnt, hs;
    logic [7:0] exp_d [8];
    int n;
    exp_d = '{8'hAA, 8'hAB, 8'hBA, 8'hBB, 8'hAA, 8'hAB, 8'hBA, 8'hBB};
    n = 0;
    cnt = 2'b00;
    do_reset();
    req_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      req_data = {cnt[1] ? 8'hBB : 8'hBA, cnt[0] ? 8'hAB : 8'hAA};
      req_last = cnt;
      #1 hs = req_valid & req_ready;
      step();
      cnt = cnt ^ hs;
      checks++; if (out_valid !== (i % 3 != 0)) begin errors++; $display("FAIL rr_valid[%0d]: got %b want %b", i, out_valid, i % 3 != 0); end
      if (out_valid === 1'b1) begin
        checks++; if (out_data !== exp_d[n]) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", n, out_data, exp_d[n]); end
        n++;
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_full();
    logic [1:0] hs;
    int b;
    b = 0;
    do_reset();
    req_valid = 2'b01;
    for (int i = 0; i < 8; i++) begin
      req_data = {8'h00, 8'h10 + 8'(b)};
      req_last = {1'b0, b == 5};
      #1 hs = req_valid & s_req_ready;
      step();
      if (hs[0]) b++;
      checks++; if (s_occ > 3'd4) begin errors++; $display("FAIL full_overflow[%0d]: got %0d want <=4", i, s_occ); end
    end
    checks++; if (s_occ !== 3'd4 || s_full !== 1'b1) begin errors++; $display("FAIL full_state: got occ=%0d full=%b want 4 1", s_occ, s_full); end
    checks++; if (s_req_ready !== 2'b00) begin errors++; $display("FAIL full_ready: got %b want 00", s_req_ready); end
    checks++; if (s_out_data !== 8'h13) begin errors++; $display("FAIL full_last_byte: got %h want 13", s_out_data); end
    req_data = 16'h0014;
    tx_done = 1'b1;
    #1;
    checks++; if (s_req_ready !== 2'b00) begin errors++; $display("FAIL full_same_cycle: got %b want 00", s_req_ready); end
    step();
    tx_done = 1'b0;
    checks++; if (s_occ !== 3'd3 || s_full !== 1'b0) begin errors++; $display("FAIL full_drain: got occ=%0d full=%b want 3 0", s_occ, s_full); end
    checks++; if (s_req_ready !== 2'b01) begin errors++; $display("FAIL full_reopen: got %b want 01", s_req_ready); end
    step();
    checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h14) begin errors++; $display("FAIL full_fifth: got v=%b d=%h want 1 14", s_out_valid, s_out_data); end
    checks++; if (s_occ !== 3'd4 || s_req_ready !== 2'b00) begin errors++; $display("FAIL full_refill: got occ=%0d ready=%b want 4 00", s_occ, s_req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_valid = 2'b01;
    req_data = 16'h0031;
    step();
    step();
    step();
    checks++; if (occupancy !== 17'd2) begin errors++; $display("FAIL sim_pre: got %0d want 2", occupancy); end
    tx_done = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL sim_ready: got %b want 01", req_ready); end
    step();
    tx_done = 1'b0;
    req_valid = 2'b00;
    checks++; if (occupancy !== 17'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL sim_occ: got occ=%0d v=%b want 2 1", occupancy, out_valid); end
    step();
    checks++; if (occupancy !== 17'd2 || underflow !== 1'b0) begin errors++; $display("FAIL sim_hold: got occ=%0d uf=%b want 2 0", occupancy, underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (occupancy !== 17'd0 || underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got occ=%0d uf=%b want 0 1", occupancy, underflow); end
    step();
    step();
    step();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", underflow); end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b want 0", underflow); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    req_valid = 2'b10;
    req_data = 16'h6100;
    step();
    checks++; if (grant_id !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL mid_grant: got id=%0d busy=%b want 1 1", grant_id, busy); end
    step();
    req_data = 16'h6200;
    step();
    checks++; if (occupancy !== 17'd2 || out_data !== 8'h62) begin errors++; $display("FAIL mid_pre: got occ=%0d d=%h want 2 62", occupancy, out_data); end
    rstn = 1'b0;
    step();
    checks++; if ({out_valid, full, busy, underflow} !== 4'b0000) begin errors++; $display("FAIL mid_flags: got %b want 0000", {out_valid, full, busy, underflow}); end
    checks++; if (out_data !== 8'h00 || occupancy !== 17'd0 || grant_id !== 3'd0) begin errors++; $display("FAIL mid_regs: got d=%h occ=%0d id=%0d want 00 0 0", out_data, occupancy, grant_id); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_ready: got %b want 00", req_ready); end
    req_valid = 2'b11;
    rstn = 1'b1;
    step();
    checks++; if (grant_id !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL mid_tie: got id=%0d busy=%b want 0 1", grant_id, busy); end
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_simultaneous();
    test_underflow();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_out_arbiter.md
# uart_out_arbiter

Round-robin arbiter placed in front of the UART output buffer that shares its single byte-write port between `N_REQ` byte producers, such as the core's `out` instruction and a diagnostic message generator. Each grant covers a whole packet, terminated by `req_last`, so records from different producers never interleave. A credit counter tracks how many accepted bytes the UART transmitter has not yet consumed, and back-pressures all producers when the buffer is full.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters. Legal range 2–8.
- `DEPTH`, default 40000: output buffer capacity in bytes.
- `CNT_W`, default 17: occupancy counter width. Must hold `DEPTH`.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rstn`  in  1: synchronous, active-low reset.
- `req_valid`  in  `N_REQ`: requester i has a byte on its lane.
- `req_data`  in  `8*N_REQ`: byte lanes. Lane i is bits `[8i+7:8i]`.
- `req_last`  in  `N_REQ`: the current byte is the final byte of the packet.
- `req_ready`  out  `N_REQ`: combinational. A byte transfers on any cycle where `valid & ready` is high.
- `out_data`  out  8: registered byte sent to the buffer write port.
- `out_valid`  out  1: registered single-cycle write strobe.
- `tx_done`  in  1: one-cycle pulse each time the transmitter consumes one byte from the buffer.
- `occupancy`  out  `CNT_W`: bytes accepted but not yet consumed.
- `full`  out  1: high when `occupancy == DEPTH`.
- `grant_id`  out  3: index of the current or most recent grantee.
- `busy`  out  1: high while in state GRANT.
- `underflow`  out  1: sticky error flag.

## Operation
- FSM states: IDLE and GRANT.
- **IDLE:**
  - Search `req_valid` round-robin, starting at `(last_grant+1) mod N_REQ`.
  - On a hit: register `grant_id` and go to GRANT.
  - On no hit: stay in IDLE.
- **GRANT:**
  - `req_ready[grant_id] = ~full`. All other `req_ready` bits are 0.
  - `req_ready` is 0 for every lane while in IDLE.
- **Handshake cycle:**
  - Next cycle, `out_data` takes that lane's byte and `out_valid` is 1. Otherwise `out_valid` is 0.
  - If `req_last` is set, go to IDLE and set `last_grant = grant_id`.
- **Packet hold:**
  - The grant persists across gaps in `req_valid`.
  - The grant persists while `full` is high.
  - There is no timeout.
- **Occupancy:**
  - +1 on a handshake.
  - −1 on `tx_done`.
  - Both in the same cycle: unchanged.
  - `tx_done` while occupancy is 0 and there is no handshake: the count stays 0 and `underflow` is set. `underflow` clears only on reset.
- **Credit safety:**
  - `occupancy` never exceeds `DEPTH`, because `ready` is gated by `full`.
  - A `tx_done` in the same cycle as `full` does not open `ready` that cycle. It opens on the next cycle.
- **`req_data` / `req_last` on non-granted lanes:** ignored.
- **Reset values (all outputs):**
  - `req_ready=0`, `out_valid=0`, `out_data=0`
  - `occupancy=0`, `full=0`, `busy=0`, `underflow=0`
  - `grant_id=0`
- **Reset, internal state:** `last_grant=N_REQ-1`, so requester 0 has first priority. State = IDLE.
- **Reset mid-packet:** the partial packet is abandoned. The buffer is reset by the same `rstn`, so zero occupancy stays consistent.

## Timing
- Arbitration latency: `req_valid` rises in IDLE at cycle t → GRANT at t+1 → earliest handshake at t+1.
- Byte latency: handshake at cycle t → `out_valid` and `out_data` at t+1, for exactly one cycle.
- Throughput:
  - Within a packet: 1 byte per cycle.
  - Between packets: one IDLE bubble. A `last` handshake at t → IDLE at t+1 → next handshake no earlier than t+2.
- `occupancy` and `full` update at t+1 for a handshake or `tx_done` occurring at t.
- A single-byte packet (`last` on the first byte) is legal and costs 2 cycles per packet.

## Test plan
1. **Single requester:** requester 0 sends 3 bytes `0x41 0x42 0x43` with `last` on `0x43`, and `tx_done` is held low. Required: `out_valid` at cycles 2–4 with those bytes in order; `occupancy` ends at 3; `busy` falls after the third byte.
2. **Round-robin:** both requesters continuously send 2-byte packets (req0 `AA AB`, req1 `BA BB`). Required: the output sequence is `AA AB BA BB AA AB …`; bytes from different packets never interleave; one bubble cycle between packets.
3. **Full back-pressure:** with `DEPTH=4`, send 6 bytes with no `tx_done`. Required:
   - `ready` drops after the 4th byte and `full=1`.
   - A `tx_done` pulse → `ready` is 1 one cycle later and the 5th byte passes.
   - `occupancy` never reads 5.
4. **Simultaneous events:** a handshake and `tx_done` in the same cycle at occupancy 2. Required: occupancy stays 2.
5. **Underflow:** `tx_done` at occupancy 0. Required: occupancy stays 0 and `underflow` latches to 1 until `rstn` is asserted.
6. **Reset mid-packet:** assert `rstn=0` after 2 of 5 bytes from requester 1. Required:
   - All outputs return to their reset values the next cycle.
   - After release, requester 0 wins a tie against requester 1.
